// File: rtl/hdlc_tx_frame_ctrl.sv
// HDLC transmit frame controller: buffers host payload bytes and sequences
// them to the bit serializer as FLAG / DATA... / FLAG, or ABORT on host request.
module hdlc_tx_frame_ctrl #(
    parameter  int BUF_DEPTH = 128,
    parameter  int DATA_W    = 8,
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1),
    localparam int PTR_W     = $clog2(BUF_DEPTH)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Tx_WrBuff,
    input  logic [DATA_W-1:0] Tx_DataIn,
    input  logic              Tx_Enable,
    input  logic              Tx_AbortFrame,
    output logic              Tx_Full,
    output logic              Tx_Done,
    output logic [CNT_W-1:0]  Tx_FrameSize,
    output logic              Tx_ValidFrame,
    output logic              Tx_AbortedTrans,
    output logic              Sym_Valid,
    output logic [1:0]        Sym_Type,
    output logic [DATA_W-1:0] Sym_Data,
    input  logic              Sym_Ready
);

    localparam logic [1:0]        SYM_FLAG  = 2'b00;
    localparam logic [1:0]        SYM_DATA  = 2'b01;
    localparam logic [1:0]        SYM_ABORT = 2'b10;
    localparam logic [DATA_W-1:0] FLAG_BYTE  = DATA_W'(8'h7E);
    localparam logic [DATA_W-1:0] ABORT_BYTE = DATA_W'(8'hFF);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_OPEN  = 3'd1,
        ST_DATA  = 3'd2,
        ST_CLOSE = 3'd3,
        ST_ABORT = 3'd4
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_buf [BUF_DEPTH];
    logic [CNT_W-1:0]  r_wr_cnt;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic              r_abort_pend;
    logic              r_aborted;
    logic              r_sym_valid;
    logic [1:0]        r_sym_type;
    logic [DATA_W-1:0] r_sym_data;

    logic              w_idle;
    logic              w_wr_accept;
    logic              w_start;
    logic              w_hs;
    logic              w_abort_req;
    logic              w_last_byte;
    logic [PTR_W-1:0]  w_rd_nxt;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_wr_accept = w_idle && Tx_WrBuff && (r_wr_cnt != CNT_W'(BUF_DEPTH));
    // A write in the same cycle as the enable joins the frame being started.
    assign w_start     = w_idle && Tx_Enable && ((r_wr_cnt != '0) || w_wr_accept);
    assign w_hs        = r_sym_valid && Sym_Ready;
    assign w_abort_req = r_abort_pend || Tx_AbortFrame;
    assign w_last_byte = ((CNT_W'(r_rd_ptr) + CNT_W'(1)) == r_wr_cnt);
    assign w_rd_nxt    = r_rd_ptr + PTR_W'(1);

    // Payload storage; contents survive reset and are only ever overwritten.
    always_ff @(posedge Clk) begin
        if (w_wr_accept) begin
            r_buf[r_wr_cnt[PTR_W-1:0]] <= Tx_DataIn;
        end
    end

    // Frame sequencer with registered symbol outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state      <= ST_IDLE;
            r_wr_cnt     <= '0;
            r_rd_ptr     <= '0;
            r_abort_pend <= 1'b0;
            r_aborted    <= 1'b0;
            r_sym_valid  <= 1'b0;
            r_sym_type   <= SYM_FLAG;
            r_sym_data   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_accept) begin
                        r_wr_cnt <= r_wr_cnt + CNT_W'(1);
                    end
                    if (w_start) begin
                        r_state     <= ST_OPEN;
                        r_rd_ptr    <= '0;
                        r_aborted   <= 1'b0;
                        r_sym_valid <= 1'b1;
                        r_sym_type  <= SYM_FLAG;
                        r_sym_data  <= FLAG_BYTE;
                    end
                end
                ST_OPEN: begin
                    if (Tx_AbortFrame) begin
                        r_abort_pend <= 1'b1;
                    end
                    if (w_hs) begin
                        if (w_abort_req) begin
                            r_state    <= ST_ABORT;
                            r_sym_type <= SYM_ABORT;
                            r_sym_data <= ABORT_BYTE;
                        end else begin
                            r_state    <= ST_DATA;
                            r_sym_type <= SYM_DATA;
                            r_sym_data <= r_buf[0];
                        end
                    end
                end
                ST_DATA: begin
                    if (Tx_AbortFrame) begin
                        r_abort_pend <= 1'b1;
                    end
                    if (w_hs) begin
                        r_rd_ptr <= w_rd_nxt;
                        if (w_abort_req) begin
                            r_state    <= ST_ABORT;
                            r_sym_type <= SYM_ABORT;
                            r_sym_data <= ABORT_BYTE;
                        end else if (w_last_byte) begin
                            r_state    <= ST_CLOSE;
                            r_sym_type <= SYM_FLAG;
                            r_sym_data <= FLAG_BYTE;
                        end else begin
                            r_sym_data <= r_buf[w_rd_nxt];
                        end
                    end
                end
                ST_CLOSE: begin
                    if (Tx_AbortFrame) begin
                        r_abort_pend <= 1'b1;
                    end
                    if (w_hs) begin
                        if (w_abort_req) begin
                            r_state    <= ST_ABORT;
                            r_sym_type <= SYM_ABORT;
                            r_sym_data <= ABORT_BYTE;
                        end else begin
                            r_state     <= ST_IDLE;
                            r_wr_cnt    <= '0;
                            r_sym_valid <= 1'b0;
                            r_sym_type  <= SYM_FLAG;
                            r_sym_data  <= '0;
                        end
                    end
                end
                ST_ABORT: begin
                    if (w_hs) begin
                        r_state      <= ST_IDLE;
                        r_wr_cnt     <= '0;
                        r_abort_pend <= 1'b0;
                        r_aborted    <= 1'b1;
                        r_sym_valid  <= 1'b0;
                        r_sym_type   <= SYM_FLAG;
                        r_sym_data   <= '0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_wr_cnt     <= '0;
                    r_abort_pend <= 1'b0;
                    r_sym_valid  <= 1'b0;
                    r_sym_type   <= SYM_FLAG;
                    r_sym_data   <= '0;
                end
            endcase
        end
    end

    assign Tx_Done         = w_idle && (r_wr_cnt == '0);
    assign Tx_Full         = (r_wr_cnt == CNT_W'(BUF_DEPTH));
    assign Tx_FrameSize    = r_wr_cnt;
    assign Tx_ValidFrame   = (r_state == ST_OPEN) || (r_state == ST_DATA) || (r_state == ST_CLOSE);
    assign Tx_AbortedTrans = r_aborted;
    assign Sym_Valid       = r_sym_valid;
    assign Sym_Type        = r_sym_type;
    assign Sym_Data        = r_sym_data;

endmodule

// File: tb/tb_hdlc_tx_frame_ctrl.sv
// Self-checking bench: directed scenarios plus randomized frames compared
// against a queue-based model of the expected symbol stream and status bits.
module tb_hdlc_tx_frame_ctrl;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       Tx_WrBuff = 1'b0;
    logic [7:0] Tx_DataIn = 8'h00;
    logic       Tx_Enable = 1'b0;
    logic       Tx_AbortFrame = 1'b0;
    logic       Tx_Full;
    logic       Tx_Done;
    logic [7:0] Tx_FrameSize;
    logic       Tx_ValidFrame;
    logic       Tx_AbortedTrans;
    logic       Sym_Valid;
    logic [1:0] Sym_Type;
    logic [7:0] Sym_Data;
    logic       Sym_Ready = 1'b0;

    always #5 Clk = ~Clk;

    hdlc_tx_frame_ctrl dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Tx_WrBuff      (Tx_WrBuff),
        .Tx_DataIn      (Tx_DataIn),
        .Tx_Enable      (Tx_Enable),
        .Tx_AbortFrame  (Tx_AbortFrame),
        .Tx_Full        (Tx_Full),
        .Tx_Done        (Tx_Done),
        .Tx_FrameSize   (Tx_FrameSize),
        .Tx_ValidFrame  (Tx_ValidFrame),
        .Tx_AbortedTrans(Tx_AbortedTrans),
        .Sym_Valid      (Sym_Valid),
        .Sym_Type       (Sym_Type),
        .Sym_Data       (Sym_Data),
        .Sym_Ready      (Sym_Ready)
    );

    int n_checks = 0;
    int n_errors = 0;
    int hs_cnt   = 0;

    // Model: buffered bytes and the symbols still owed to the serializer ({type,data}).
    logic [7:0] m_buf [$];
    logic [9:0] exp_q [$];
    bit         m_abort_pend = 1'b0;
    bit         m_aborted    = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic [9:0] f;
        @(negedge Clk);
        check_val("sym_valid", Sym_Valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            f = exp_q[0];
            check_val("sym_type", Sym_Type, f[9:8]);
            check_val("sym_data", Sym_Data, f[7:0]);
        end
        check_val("tx_done", Tx_Done, (exp_q.size() == 0) && (m_buf.size() == 0));
        check_val("tx_full", Tx_Full, m_buf.size() == 128);
        check_val("tx_framesize", Tx_FrameSize, m_buf.size());
        check_val("tx_validframe", Tx_ValidFrame, (exp_q.size() != 0) && (exp_q[0][9:8] != 2'b10));
        check_val("tx_abortedtrans", Tx_AbortedTrans, m_aborted);
        if (Rst) begin
            m_buf.delete();
            exp_q.delete();
            m_abort_pend = 1'b0;
            m_aborted    = 1'b0;
        end else if (exp_q.size() == 0) begin
            if (Tx_WrBuff && m_buf.size() < 128) m_buf.push_back(Tx_DataIn);
            if (Tx_Enable && m_buf.size() > 0) begin
                exp_q.push_back({2'b00, 8'h7E});
                foreach (m_buf[i]) exp_q.push_back({2'b01, m_buf[i]});
                exp_q.push_back({2'b00, 8'h7E});
                m_aborted = 1'b0;
            end
        end else begin
            if (Tx_AbortFrame && !m_abort_pend) begin
                m_abort_pend = 1'b1;
                f = exp_q[0];
                exp_q.delete();
                exp_q.push_back(f);
                exp_q.push_back({2'b10, 8'hFF});
            end
            if (Sym_Ready) begin
                f = exp_q.pop_front();
                hs_cnt++;
                if (f[9:8] == 2'b10) begin
                    m_aborted    = 1'b1;
                    m_abort_pend = 1'b0;
                    m_buf.delete();
                end else if (exp_q.size() == 0) begin
                    m_buf.delete();
                end
            end
        end
        @(posedge Clk);
        #1;
        Tx_WrBuff     = 1'b0;
        Tx_Enable     = 1'b0;
        Tx_AbortFrame = 1'b0;
        Rst           = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b);
        Tx_WrBuff = 1'b1;
        Tx_DataIn = b;
        step();
    endtask

    task automatic enable();
        Tx_Enable = 1'b1;
        step();
    endtask

    // mode 0: ready high, 1: ready toggles starting low, 2: random ready
    task automatic run_frame(input int mode, input int abort_at, output int cycles);
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 2000) begin
            case (mode)
                0:       Sym_Ready = 1'b1;
                1:       Sym_Ready = cycles[0];
                default: Sym_Ready = 1'($urandom % 2);
            endcase
            if (cycles == abort_at) Tx_AbortFrame = 1'b1;
            step();
            cycles++;
        end
        check_val("frame_timeout", exp_q.size(), 0);
        Sym_Ready = 1'b1;
        step();
    endtask

    initial begin
        int cyc;
        int hs0;
        int n;
        int ab_at;

        Rst = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        check_val("rst_sym_valid", Sym_Valid, 0);
        check_val("rst_sym_type", Sym_Type, 0);
        check_val("rst_sym_data", Sym_Data, 0);
        check_val("rst_done", Tx_Done, 1);
        check_val("rst_framesize", Tx_FrameSize, 0);
        step();

        // Basic three-byte frame, ready held high.
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        check_val("size_3", Tx_FrameSize, 3);
        enable();
        run_frame(0, -1, cyc);
        check_val("cycles_3byte", cyc, 5);

        // Full buffer, overflow write dropped, 130 handshakes.
        for (int i = 0; i < 128; i++) write_byte(8'(i));
        write_byte(8'hAA);
        check_val("full_flag", Tx_Full, 1);
        check_val("full_size", Tx_FrameSize, 128);
        hs0 = hs_cnt;
        enable();
        run_frame(0, -1, cyc);
        check_val("hs_128", hs_cnt - hs0, 130);

        // Four bytes with ready toggling.
        for (int i = 0; i < 4; i++) write_byte(8'hA0 + 8'(i));
        enable();
        run_frame(1, -1, cyc);

        // Abort while DATA byte 2 is stalled.
        for (int i = 0; i < 4; i++) write_byte(8'h40 + 8'(i));
        enable();
        Sym_Ready = 1'b1;
        step();
        step();
        Sym_Ready = 1'b0;
        Tx_AbortFrame = 1'b1;
        step();
        step();
        run_frame(0, -1, cyc);
        check_val("aborted_set", Tx_AbortedTrans, 1);
        write_byte(8'h5A);
        enable();
        check_val("aborted_clr", Tx_AbortedTrans, 0);
        run_frame(0, -1, cyc);

        // Enable with empty buffer and abort in idle have no effect.
        enable();
        Tx_AbortFrame = 1'b1;
        step();
        check_val("empty_en_valid", Sym_Valid, 0);
        check_val("empty_en_done", Tx_Done, 1);

        // Reset mid-DATA.
        for (int i = 0; i < 5; i++) write_byte(8'hC0 + 8'(i));
        enable();
        Sym_Ready = 1'b1;
        step();
        step();
        Rst = 1'b1;
        step();
        check_val("midrst_valid", Sym_Valid, 0);
        check_val("midrst_done", Tx_Done, 1);
        check_val("midrst_size", Tx_FrameSize, 0);
        check_val("midrst_aborted", Tx_AbortedTrans, 0);
        step();

        // Randomized frames.
        for (int k = 0; k < 30; k++) begin
            n = ($urandom % 8 == 0) ? 128 : int'($urandom_range(1, 40));
            for (int i = 0; i < n - 1; i++) write_byte(8'($urandom));
            if (n == 128) begin
                write_byte(8'($urandom));
                write_byte(8'($urandom));
                enable();
            end else if ($urandom % 4 == 0) begin
                Tx_WrBuff = 1'b1;
                Tx_DataIn = 8'($urandom);
                Tx_Enable = 1'b1;
                step();
            end else begin
                write_byte(8'($urandom));
                enable();
            end
            ab_at = ($urandom % 3 == 0) ? int'($urandom_range(0, 2 * n + 4)) : -1;
            run_frame(2, ab_at, cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hdlc_tx_frame_ctrl.md
# hdlc_tx_frame_ctrl

Transmit-side frame controller for the HDLC core. It buffers up to 128 payload bytes written by the host and, on command, sequences them into the downstream bit serializer as a symbol stream: opening flag, payload bytes, closing flag, or an abort pattern when the host aborts. It owns the Tx status bits (Tx_Done, Tx_Full, Tx_ValidFrame, Tx_AbortedTrans, Tx_FrameSize). Zero-bit insertion and FCS generation are downstream and outside this block.

## Interface

Parameters:
- BUF_DEPTH, 128, payload buffer depth in bytes; Tx_FrameSize must hold BUF_DEPTH.
- DATA_W, 8, byte width.

Ports:
- Clk  in  1  core clock; all logic is on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- Tx_WrBuff  in  1  host write strobe; pushes Tx_DataIn into the buffer.
- Tx_DataIn  in  8  host write data.
- Tx_Enable  in  1  single-cycle pulse; starts transmission of the buffered frame.
- Tx_AbortFrame  in  1  single-cycle pulse; aborts the frame in progress.
- Tx_Full  out  1  buffer holds BUF_DEPTH bytes.
- Tx_Done  out  1  controller idle and buffer empty.
- Tx_FrameSize  out  8  number of bytes currently buffered.
- Tx_ValidFrame  out  1  frame transmission in progress.
- Tx_AbortedTrans  out  1  sticky: last frame ended by abort.
- Sym_Valid  out  1  symbol offered to the serializer.
- Sym_Type  out  2  00 FLAG, 01 DATA, 10 ABORT; 11 unused.
- Sym_Data  out  8  symbol byte.
- Sym_Ready  in  1  serializer accepts the symbol; a handshake is Sym_Valid && Sym_Ready.

## Operation

- The buffer is a BUF_DEPTH x 8 array with a write count wr_cnt (0..BUF_DEPTH) and a read pointer rd_ptr.
- State machine: IDLE, OPEN_FLAG, DATA, CLOSE_FLAG, ABORT.
- IDLE:
  - Tx_WrBuff && !Tx_Full: write to buf[wr_cnt], wr_cnt+1.
  - A write while full is dropped; wr_cnt is unchanged.
  - Tx_Enable && wr_cnt>0 -> OPEN_FLAG, rd_ptr=0, Tx_AbortedTrans cleared.
  - Tx_Enable with wr_cnt==0 is ignored.
  - Tx_AbortFrame is ignored.
- Outside IDLE, Tx_WrBuff and Tx_Enable are ignored.
- OPEN_FLAG: Sym_Type=FLAG, Sym_Data=0x7E. On handshake -> DATA.
- DATA: Sym_Type=DATA, Sym_Data=buf[rd_ptr]. On handshake, rd_ptr+1; when rd_ptr==wr_cnt-1 -> CLOSE_FLAG.
- CLOSE_FLAG: Sym_Type=FLAG, Sym_Data=0x7E. On handshake -> IDLE, wr_cnt=0.
- Abort:
  - Tx_AbortFrame in OPEN_FLAG, DATA or CLOSE_FLAG sets abort_pend.
  - On the next handshake (including one in the same cycle as the pulse) the state goes to ABORT instead of the normal successor.
  - The accepted symbol counts as sent.
  - The offered symbol is never withdrawn.
- ABORT: Sym_Type=ABORT, Sym_Data=0xFF. On handshake -> IDLE, wr_cnt=0, abort_pend=0, Tx_AbortedTrans=1.
- Sym_Valid=1 in every state except IDLE. Sym_Type and Sym_Data are stable while Sym_Valid && !Sym_Ready.
- Status outputs:
  - Tx_ValidFrame=1 in OPEN_FLAG, DATA, CLOSE_FLAG; 0 in IDLE and ABORT.
  - Tx_Done = (state==IDLE) && (wr_cnt==0).
  - Tx_Full = (wr_cnt==BUF_DEPTH).
  - Tx_FrameSize = wr_cnt; it stays constant during transmission.

## Timing

- Reset values: state IDLE, wr_cnt 0, rd_ptr 0, abort_pend 0.
- Outputs at reset: Sym_Valid 0, Sym_Type 00, Sym_Data 0x00, Tx_Done 1, Tx_Full 0, Tx_FrameSize 0, Tx_ValidFrame 0, Tx_AbortedTrans 0.
- Buffer contents are not reset.
- All outputs are registered or decoded from registered state. There is no combinational path from Sym_Ready to Sym_Valid.
- A write in cycle n is reflected in Tx_FrameSize and Tx_Full at n+1.
- Tx_Enable in cycle n gives Sym_Valid=1, FLAG at n+1.
- With Sym_Ready held high, an N-byte frame uses exactly N+2 consecutive handshake cycles. Tx_Done returns at the cycle after the closing-flag handshake.
- Sym_Ready low stalls the state machine indefinitely with no loss.
- Tx_WrBuff and Tx_Enable in the same IDLE cycle: the write is accepted and the frame starts with wr_cnt+1 bytes.
- Rst asserted mid-frame: the next edge returns to reset values and Sym_Valid drops without a closing flag. Tx_AbortedTrans is not set.
- Buffer boundaries:
  - At BUF_DEPTH bytes, Tx_Full=1 and the 129th write is dropped.
  - A 128-byte frame sends all bytes; the rd_ptr wrap is never reached.

## Test plan

- Reset, write 0x11,0x22,0x33, pulse Tx_Enable, hold Sym_Ready=1 -> symbols FLAG 7E, DATA 11, 22, 33, FLAG 7E on 5 consecutive cycles; Tx_ValidFrame high for those 5 cycles; Tx_Done=1 and Tx_FrameSize=0 the cycle after.
- Write 128 bytes 0x00..0x7F, then a 129th write 0xAA -> Tx_Full=1, Tx_FrameSize=128; transmitted payload is 0x00..0x7F with no 0xAA; 130 handshakes.
- 4-byte frame, Sym_Ready toggled 0/1 every cycle -> same 6 symbols in order, each held stable while Sym_Ready=0.
- Pulse Tx_AbortFrame while DATA byte 2 is offered with Sym_Ready=0, then release Sym_Ready -> byte 2 accepted, then ABORT 0xFF, then IDLE; Tx_AbortedTrans=1, Tx_ValidFrame=0 during ABORT; the next Tx_Enable clears Tx_AbortedTrans.
- Tx_Enable with empty buffer -> no Sym_Valid and Tx_Done stays 1; Tx_AbortFrame in IDLE -> no effect.
- Assert Rst for one cycle mid-DATA -> next cycle Sym_Valid=0, Tx_Done=1, Tx_FrameSize=0, Tx_AbortedTrans=0.
